// File: rtl/line_dump_monitor.sv
// line_dump_monitor: watches the fetch PC and, when the program reaches END_PC,
// freezes the core and streams data-memory lines FIRST_LINE..LAST_LINE out as
// WORD_W-bit words over a valid/ready handshake, word 0 (LSBs) of each line first.
// Optional feature: define DUMP_CHECKSUM_EN to get a running XOR of every accepted
// word on checksum; without it checksum is tied to zero.
module line_dump_monitor #(
   parameter int                ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] END_PC     = 'h80,
   parameter int                LINE_W     = 512,
   parameter int                WORD_W     = 32,
   parameter int                IDX_W      = 8,
   parameter int                FIRST_LINE = 2,
   parameter int                LAST_LINE  = 7,
   localparam int               WPL        = LINE_W / WORD_W,
   localparam int               WW         = (WPL > 1) ? $clog2(WPL) : 1
) (
   input  logic              CLK,
   input  logic              CLR,
   input  logic [ADDR_W-1:0] pc,
   input  logic              pc_valid,
   output logic              mem_rd_en,
   output logic [IDX_W-1:0]  mem_rd_idx,
   input  logic [LINE_W-1:0] mem_rd_data,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [WORD_W-1:0] dump_data,
   output logic [IDX_W-1:0]  dump_line,
   output logic [WW-1:0]     dump_word,
   output logic              dump_last,
   output logic              halt,
   output logic              done,
   output logic [WORD_W-1:0] checksum
);

   localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(FIRST_LINE);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LAST_LINE);
   localparam logic [WW-1:0]    LAST_WORD = WW'(WPL - 1);

   // Reject configurations that cannot produce a whole-word, in-range dump.
   if (LINE_W % WORD_W != 0) begin : g_bad_word_w
      $error("line_dump_monitor: LINE_W must be a multiple of WORD_W");
   end
   if (FIRST_LINE > LAST_LINE) begin : g_bad_range
      $error("line_dump_monitor: FIRST_LINE must not exceed LAST_LINE");
   end
   if (LAST_LINE >= 2**IDX_W) begin : g_bad_idx
      $error("line_dump_monitor: LAST_LINE does not fit in IDX_W bits");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WAIT,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t             state;
   logic [IDX_W-1:0]   line_cnt;
   logic [WW-1:0]      word_cnt;
   logic [LINE_W-1:0]  line_buf;
   logic               accept;

   // dump_valid is only ever high in SHIFT, so this is the word-accept strobe.
   assign accept = dump_valid && dump_ready;

   // Control FSM: trigger detect, one-cycle line read, word walk, terminal DONE.
   always_ff @(posedge CLK) begin
      if (!CLR) begin
         state      <= S_IDLE;
         line_cnt   <= '0;
         word_cnt   <= '0;
         mem_rd_en  <= 1'b0;
         mem_rd_idx <= '0;
         dump_valid <= 1'b0;
         halt       <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (pc_valid && (pc == END_PC)) begin
                  state      <= S_READ;
                  line_cnt   <= FIRST_IDX;
                  word_cnt   <= '0;
                  mem_rd_en  <= 1'b1;
                  mem_rd_idx <= FIRST_IDX;
                  halt       <= 1'b1;
               end
            end
            S_READ: begin
               mem_rd_en <= 1'b0;
               state     <= S_WAIT;
            end
            S_WAIT: begin
               dump_valid <= 1'b1;
               state      <= S_SHIFT;
            end
            S_SHIFT: begin
               if (accept) begin
                  if (word_cnt == LAST_WORD) begin
                     dump_valid <= 1'b0;
                     word_cnt   <= '0;
                     if (line_cnt == LAST_IDX) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                     end else begin
                        line_cnt   <= line_cnt + IDX_W'(1);
                        mem_rd_en  <= 1'b1;
                        mem_rd_idx <= line_cnt + IDX_W'(1);
                        state      <= S_READ;
                     end
                  end else begin
                     word_cnt <= word_cnt + WW'(1);
                  end
               end
            end
            S_DONE: begin
               state <= S_DONE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Line buffer holds the fetched line for the whole SHIFT phase; no reset needed
   // because it is masked off the output whenever dump_valid is low.
   always_ff @(posedge CLK) begin
      if (state == S_WAIT) begin
         line_buf <= mem_rd_data;
      end
   end

   // Word outputs are pure functions of held registers, so they stay put while stalled.
   assign dump_data = dump_valid ? line_buf[int'(word_cnt) * WORD_W +: WORD_W] : '0;
   assign dump_line = dump_valid ? line_cnt : '0;
   assign dump_word = dump_valid ? word_cnt : '0;
   assign dump_last = dump_valid && (line_cnt == LAST_IDX) && (word_cnt == LAST_WORD);

`ifdef DUMP_CHECKSUM_EN
   logic [WORD_W-1:0] csum;

   // Running XOR of accepted words; no accepts occur in DONE so it freezes there.
   always_ff @(posedge CLK) begin
      if (!CLR) begin
         csum <= '0;
      end else if (accept) begin
         csum <= csum ^ dump_data;
      end
   end

   assign checksum = csum;
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_line_dump_monitor.sv
// Directed bench for line_dump_monitor: default-size instance plus a one-line,
// four-word instance, with a registered line memory model on each.
`timescale 1ns/1ps
module tb_line_dump_monitor;

   localparam int NWORDS = 96;

   logic          CLK = 1'b0;
   logic          CLR = 1'b0;

   // default instance
   logic [31:0]   pc = '0;
   logic          pc_valid = 1'b0;
   logic          mem_rd_en;
   logic [7:0]    mem_rd_idx;
   logic [511:0]  mem_rd_data = '0;
   logic          dump_valid;
   logic          dump_ready = 1'b0;
   logic [31:0]   dump_data;
   logic [7:0]    dump_line;
   logic [3:0]    dump_word;
   logic          dump_last;
   logic          halt;
   logic          done;
   logic [31:0]   checksum;

   // small instance: one 128-bit line
   logic [31:0]   s_pc = '0;
   logic          s_pc_valid = 1'b0;
   logic          s_mem_rd_en;
   logic [7:0]    s_mem_rd_idx;
   logic [127:0]  s_mem_rd_data = '0;
   logic          s_dump_valid;
   logic          s_dump_ready = 1'b0;
   logic [31:0]   s_dump_data;
   logic [7:0]    s_dump_line;
   logic [1:0]    s_dump_word;
   logic          s_dump_last;
   logic          s_halt;
   logic          s_done;
   logic [31:0]   s_checksum;

   int            n_cmp = 0;
   int            n_bad = 0;
   bit            ffpat = 1'b0;

   line_dump_monitor u_dut (
      .CLK(CLK), .CLR(CLR), .pc(pc), .pc_valid(pc_valid),
      .mem_rd_en(mem_rd_en), .mem_rd_idx(mem_rd_idx), .mem_rd_data(mem_rd_data),
      .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
      .dump_line(dump_line), .dump_word(dump_word), .dump_last(dump_last),
      .halt(halt), .done(done), .checksum(checksum)
   );

   line_dump_monitor #(.LINE_W(128), .WORD_W(32), .FIRST_LINE(0), .LAST_LINE(0)) u_small (
      .CLK(CLK), .CLR(CLR), .pc(s_pc), .pc_valid(s_pc_valid),
      .mem_rd_en(s_mem_rd_en), .mem_rd_idx(s_mem_rd_idx), .mem_rd_data(s_mem_rd_data),
      .dump_valid(s_dump_valid), .dump_ready(s_dump_ready), .dump_data(s_dump_data),
      .dump_line(s_dump_line), .dump_word(s_dump_word), .dump_last(s_dump_last),
      .halt(s_halt), .done(s_done), .checksum(s_checksum)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] word_of(input int ln, input int w, input bit ff);
      if (ff) return (ln == 7 && w == 15) ? 32'h12345678 : 32'hFFFFFFFF;
      return {ln[15:0], w[15:0]};
   endfunction

   always @(posedge CLK) begin
      if (mem_rd_en)
         for (int w = 0; w < 16; w++) mem_rd_data[w*32 +: 32] <= word_of(int'(mem_rd_idx), w, ffpat);
      if (s_mem_rd_en)
         for (int w = 0; w < 4; w++) s_mem_rd_data[w*32 +: 32] <= word_of(int'(s_mem_rd_idx), w, 1'b0);
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge CLK);
      CLR = 1'b0; pc_valid = 1'b0; s_pc_valid = 1'b0; dump_ready = 1'b0; s_dump_ready = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      CLR = 1'b1;
   endtask

   task automatic check_zero(input string tag);
      check_val({tag, "_ctl"}, {mem_rd_en, mem_rd_idx, dump_valid, dump_last, halt, done, dump_line, dump_word}, '0);
      check_val({tag, "_data"}, {checksum, dump_data}, '0);
   endtask

   // Called at a negedge with CLR released; returns at the negedge where the first word is up.
   task automatic trigger();
      pc = 32'h80; pc_valid = 1'b1;
      @(negedge CLK);
      check_val("trig_ctl", {halt, mem_rd_en, mem_rd_idx, dump_valid}, {1'b1, 1'b1, 8'd2, 1'b0});
      @(negedge CLK);
      check_val("read_one_cycle", {halt, mem_rd_en, dump_valid}, 3'b100);
      @(negedge CLK);
      check_val("first_valid", dump_valid, 1'b1);
   endtask

   // pc stays at 0x80/valid throughout, so any retrigger would corrupt the sequence.
   task automatic stream(input int mode, input int stop_at, output int acc, output logic [31:0] x);
      int cyc = 0;
      int rd = 1;
      int ln, w;
      bit pstall = 1'b0;
      logic [45:0] pvec = '0;
      logic [31:0] e;
      acc = 0; x = '0;
      while (!done && acc < stop_at && cyc < 4000) begin
         dump_ready = (mode == 0) || (cyc % 2 == 0);
         if (mem_rd_en) begin
            check_val("rd_idx", mem_rd_idx, 8'(2 + rd));
            rd++;
         end
         if (pstall) check_val("stall_hold", {dump_valid, dump_last, dump_line, dump_word, dump_data}, pvec);
         pstall = dump_valid && !dump_ready;
         pvec = {dump_valid, dump_last, dump_line, dump_word, dump_data};
         if (dump_valid && dump_ready) begin
            ln = 2 + acc / 16; w = acc % 16;
            e = word_of(ln, w, ffpat);
            check_val("word", {dump_last, dump_line, dump_word, dump_data},
                      {acc == NWORDS - 1, 8'(ln), 4'(w), e});
            x ^= e;
            acc++;
         end
         @(negedge CLK);
         cyc++;
      end
   endtask

   task automatic final_checks(input int acc, input logic [31:0] x);
      check_val("word_count", acc, NWORDS);
      check_val("done_state", {done, halt, dump_valid, mem_rd_en, dump_last}, 5'b11000);
`ifdef DUMP_CHECKSUM_EN
      check_val("checksum", checksum, x);
`else
      check_val("checksum", checksum, 32'h0);
`endif
      repeat (3) @(negedge CLK);
      check_val("done_hold", {done, halt, dump_valid, mem_rd_en}, 4'b1100);
   endtask

   initial begin
      int acc, cnt, cyc;
      bit seen;
      logic [31:0] x;

      do_reset();
      @(negedge CLK);
      check_zero("reset");

      // no trigger: END_PC without valid, then valid with another PC
      seen = 1'b0;
      pc = 32'h80; pc_valid = 1'b0;
      repeat (3) begin @(negedge CLK); seen |= halt | mem_rd_en; end
      pc = 32'h84; pc_valid = 1'b1;
      repeat (3) begin @(negedge CLK); seen |= halt | mem_rd_en; end
      check_val("no_trigger", seen, 1'b0);
      pc_valid = 1'b0;
      @(negedge CLK);

      // full dump, ready always high
      trigger();
      stream(0, 1000, acc, x);
      final_checks(acc, x);

      // full dump, ready toggling
      do_reset();
      trigger();
      stream(1, 1000, acc, x);
      final_checks(acc, x);

      // reset mid-dump, then restart from line 2 word 0
      do_reset();
      trigger();
      stream(0, 20, acc, x);
      check_val("partial_count", acc, 20);
      CLR = 1'b0; pc_valid = 1'b0; dump_ready = 1'b0;
      @(negedge CLK);
      check_zero("mid_reset");
      CLR = 1'b1;
      @(negedge CLK);
      trigger();
      stream(0, 1000, acc, x);
      final_checks(acc, x);

      // checksum pattern
      do_reset();
      ffpat = 1'b1;
      trigger();
      stream(0, 1000, acc, x);
      final_checks(acc, x);
`ifdef DUMP_CHECKSUM_EN
      check_val("checksum_const", checksum, 32'hEDCBA987);
`else
      check_val("checksum_const", checksum, 32'h0);
`endif
      ffpat = 1'b0;

      // one-line, four-word configuration
      do_reset();
      @(negedge CLK);
      s_pc = 32'h80; s_pc_valid = 1'b1; s_dump_ready = 1'b1;
      cnt = 0; cyc = 0;
      while (!s_done && cyc < 100) begin
         if (s_dump_valid) begin
            check_val("small_word", {s_dump_last, s_dump_line, s_dump_word, s_dump_data},
                      {cnt == 3, 8'd0, 2'(cnt), word_of(0, cnt, 1'b0)});
            cnt++;
         end
         @(negedge CLK);
         cyc++;
      end
      check_val("small_count", cnt, 4);
      check_val("small_done", {s_done, s_halt, s_dump_valid}, 3'b110);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
